// File: rtl/sm_hex_scanner.sv
// Multiplexed hex display scanner: time-slices DIGITS seven-segment digits with
// anode dead-time, leading-zero blanking and tear-free frame-boundary updates.
module sm_hex_scanner #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 256,
  parameter int GHOST_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  output logic [6:0]          segments,
  output logic                dot,
  output logic [DIGITS-1:0]   anodes,
  output logic                frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DOT_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dot_q, dot_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                boundary;
  logic                digit_blank;
  logic [4*DIGITS-1:0] upper_nibbles;
  logic [DIGITS-1:0]   an_onehot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    seg_d        = SEG_OFF;
    dot_d        = DOT_OFF;
    an_d         = AN_OFF;
    an_onehot    = '0;
    boundary     = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    frame_done_d = boundary;

    // A digit is a leading zero when it and every nibble above it are zero.
    upper_nibbles = disp_data_q >> (4 * idx_q);
    digit_blank   = BLANK_LEADING && (idx_q != '0) && (upper_nibbles == '0);

    if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp;
    end

    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      seg_d = digit_blank ? SEG_OFF
                          : (hex_to_seg(upper_nibbles[3:0]) ^ {7{SEG_ACTIVE_LOW}});
      dot_d = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;

      if (32'(cnt_q) >= 32'(GHOST_CYCLES)) begin
        an_onehot[idx_q] = 1'b1;
        an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
    end

    // A load coinciding with the boundary goes straight to the display so a
    // frame never mixes two loads.
    if (boundary) begin
      disp_data_d = load ? data : pend_data_q;
      disp_dp_d   = load ? dp   : pend_dp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dot_q        <= DOT_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dot_q        <= dot_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = seg_q;
  assign dot        = dot_q;
  assign anodes     = an_q;
  assign frame_done = frame_done_q;

endmodule
